// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, WIDTH steps per result.
// Optional two's-complement input handling is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_shift;
   logic [4*DIGITS-1:0] r_scratch;
   logic [4*DIGITS-1:0] r_bcd;
   logic [CW-1:0]       r_cnt;
   logic                r_sign;
   logic                r_neg;

   logic                w_load;
   logic                w_step;
   logic                w_last;
   logic                w_sign_in;
   logic [WIDTH-1:0]    w_mag;
   logic [4*DIGITS-1:0] w_adj;
   logic [4*DIGITS-1:0] w_scratch_nxt;
   logic [WIDTH-1:0]    w_shift_nxt;

`ifdef BIN2BCD_SIGNED_EN
   // Negating the most negative value wraps to itself, which read unsigned is its full magnitude.
   assign w_sign_in = bin[WIDTH-1];
   assign w_mag     = w_sign_in ? ((~bin) + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;
`else
   assign w_sign_in = 1'b0;
   assign w_mag     = bin;
`endif

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
         end
      end
   end

   assign {w_scratch_nxt, w_shift_nxt} = {w_adj, r_shift} << 1;
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = CONV;
            end
         end
         CONV: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_sign    <= 1'b0;
         r_bcd     <= '0;
         r_neg     <= 1'b0;
      end else if (w_load) begin
         r_shift   <= w_mag;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_sign    <= w_sign_in;
      end else if (w_step) begin
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_cnt     <= r_cnt + CW'(1);
         // The final step's result is published directly so done and bcd rise together.
         if (w_last) begin
            r_bcd <= w_scratch_nxt;
            r_neg <= r_sign;
         end
      end
   end

   assign bcd = r_bcd;
   assign neg = r_neg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random conversions
// compared against an arithmetic decimal-digit reference model.
module tb_bin2bcd_seq;

   localparam int W = 8;
`ifdef BIN2BCD_SIGNED_EN
   localparam bit SIGNED = 1'b1;
`else
   localparam bit SIGNED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic        neg;

   int          cmp_cnt  = 0;
   int          fail_cnt = 0;
   logic [11:0] exp_bcd  = '0;
   logic        exp_neg  = 1'b0;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .neg   (neg)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ref_bcd(input logic [7:0] v);
      int m;
      m = int'(v);
      if (SIGNED && v[7]) m = 256 - m;
      return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic ref_neg(input logic [7:0] v);
      return SIGNED ? v[7] : 1'b0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full conversion, checking every cycle; optional start/bin poke while converting.
   task automatic run_conv(input logic [7:0] v, input int poke_cyc, input logic [7:0] poke_val);
      logic [11:0] hold_bcd;
      logic        hold_neg;
      hold_bcd = exp_bcd;
      hold_neg = exp_neg;
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bin   = 8'($urandom);
      check("busy_after_accept", busy, 1);
      check("done_after_accept", done, 0);
      for (int k = 1; k <= W + 2; k++) begin
         @(negedge clk);
         if (k < W) begin
            check("busy_conv", busy, 1);
            check("done_conv", done, 0);
            check("bcd_hold_conv", bcd, hold_bcd);
            check("neg_hold_conv", neg, hold_neg);
         end else if (k == W) begin
            exp_bcd = ref_bcd(v);
            exp_neg = ref_neg(v);
            check("done_pulse", done, 1);
            check("busy_at_done", busy, 0);
            check("bcd_result", bcd, exp_bcd);
            check("neg_result", neg, exp_neg);
         end else begin
            check("done_after", done, 0);
            check("busy_after", busy, 0);
            check("bcd_stable_after", bcd, exp_bcd);
         end
         if (k == poke_cyc) begin
            start = 1'b1;
            bin   = poke_val;
         end else begin
            start = 1'b0;
            bin   = 8'($urandom);
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int n_done;
      logic [7:0] v;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      bin   = 8'd55;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bcd", bcd, 0);
      check("rst_neg", neg, 0);
      start = 1'b0;
      rst   = 1'b0;

      run_conv(8'd255, 0, 8'd0);
      check("bcd_255_const", bcd, SIGNED ? 12'h001 : 12'h255);
      run_conv(8'd0, 0, 8'd0);
      check("bcd_0_const", bcd, 12'h000);
      run_conv(8'd99, 0, 8'd0);
      check("bcd_99_const", bcd, 12'h099);

      // start re-pulsed mid-conversion with a different value must be ignored
      run_conv(8'd123, 3, 8'd77);
      repeat (W + 2) begin
         @(negedge clk);
         check("no_extra_done", done, 0);
      end

      // reset mid-conversion aborts with no done
      @(negedge clk);
      bin   = 8'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_bcd", bcd, 0);
      check("abort_neg", neg, 0);
      exp_bcd = '0;
      exp_neg = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      run_conv(8'd42, 0, 8'd0);
      check("bcd_42_const", bcd, 12'h042);

      // signed corner values (plain unsigned expectations when the macro is off)
      run_conv(8'h80, 0, 8'd0);
      run_conv(8'hFF, 0, 8'd0);
      run_conv(8'h7F, 0, 8'd0);
`ifdef BIN2BCD_SIGNED_EN
      check("signed_7f_const", {neg, bcd}, {1'b0, 12'h127});
`endif

      // start held high: back-to-back conversions every W+2 cycles
      n_done = 0;
      @(negedge clk);
      bin   = 8'd7;
      start = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         check("b2b_done", done, ((k % (W + 2)) == W) ? 1 : 0);
         if (done) begin
            n_done++;
            check("b2b_bcd", bcd, 12'h007);
         end
      end
      start = 1'b0;
      check("b2b_count", n_done, 3);
      exp_bcd = 12'h007;
      exp_neg = 1'b0;
      repeat (W + 2) @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         v = 8'($urandom);
         run_conv(v, 0, 8'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
